// File: rtl/result_seg7_display_pkg.sv
// result_seg7_display_pkg
//   Shared definitions for the result 7-segment display stage: FSM state
//   encodings, the blank segment pattern, the 16-entry hex glyph table
//   (active-low, bit order {g,f,e,d,c,b,a}), and the shift-add-3 digit
//   correction helper.
package result_seg7_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
        logic [6:0] p;
        p = SEG_BLANK;
        case (nib)
            4'h0: p = SEG_0;
            4'h1: p = SEG_1;
            4'h2: p = SEG_2;
            4'h3: p = SEG_3;
            4'h4: p = SEG_4;
            4'h5: p = SEG_5;
            4'h6: p = SEG_6;
            4'h7: p = SEG_7;
            4'h8: p = SEG_8;
            4'h9: p = SEG_9;
            4'hA: p = SEG_A;
            4'hB: p = SEG_B;
            4'hC: p = SEG_C;
            4'hD: p = SEG_D;
            4'hE: p = SEG_E;
            4'hF: p = SEG_F;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // A BCD digit of 5 or more would overflow past 9 when doubled by the
    // next shift, so it is pre-corrected by +3.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/result_seg7_display_decoder.sv
// result_seg7_display_decoder
//   Combinational nibble to 7-segment glyph decoder.
//   Ports:
//     nibble  in   4   digit value 0-F
//     blank   in   1   force all segments off
//     seg     out  7   segments {g,f,e,d,c,b,a}, active-low
module result_seg7_display_decoder
    import result_seg7_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg_pattern(nibble);

endmodule

// File: rtl/result_seg7_display.sv
// result_seg7_display
//   Output stage for the core's result port. Watches data_in for changes,
//   converts the value to BCD with a sequential shift-add-3 engine and drives
//   a multiplexed DIGITS-digit 7-segment display with leading-zero blanking.
//
//   Build option: define HEX_DISPLAY_EN to add the hex_sel input, which
//   bypasses the BCD engine and shows the raw value as hex digits.
//
//   Ports:
//     clk      in   1          system clock, rising edge
//     rst      in   1          asynchronous reset, active-low
//     data_in  in   DATA_W     result value from core (no strobe)
//     hex_sel  in   1          hex display mode (HEX_DISPLAY_EN only)
//     busy     out  1          conversion in progress
//     bcd_out  out  4*DIGITS   last completed conversion
//     an       out  DIGITS     digit enables, active-low, one-hot-zero
//     seg      out  7          segments {g,f,e,d,c,b,a}, active-low
//     dp       out  1          decimal point, always off
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for data_in (or mode) to differ from last capture
//   S_SHIFT | shift-add-3, one input bit per clock, DATA_W clocks
//   S_DONE  | publish accumulator to bcd_out, drop busy
module result_seg7_display
    import result_seg7_display_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     data_in,
`ifdef HEX_DISPLAY_EN
    input  logic                  hex_sel,
`endif
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = $clog2(REFRESH_DIV);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   last_val;
    logic                last_mode;
    logic [DATA_W-1:0]   shreg;
    logic [BCD_W-1:0]    accum;
    logic [BCD_W-1:0]    accum_adj;
    logic [ITER_W-1:0]   iter;
    logic                mode_in;
    logic                trigger;
    logic                capture;
    logic                shift_en;
    logic                finish;

`ifdef HEX_DISPLAY_EN
    assign mode_in = hex_sel;
`else
    assign mode_in = 1'b0;
`endif

    // The mode bit is part of the compare so a mode toggle alone redraws.
    assign trigger = (data_in != last_val) || (mode_in != last_mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    capture = 1'b1;
                    state_d = mode_in ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (iter == ITER_W'(DATA_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accum_adj = accum;
        for (int k = 0; k < DIGITS; k++) begin
            accum_adj[4*k +: 4] = bcd_adjust(accum[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_val  <= '0;
            last_mode <= 1'b0;
            shreg     <= '0;
            accum     <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            bcd_out   <= '0;
        end else begin
            if (capture) begin
                last_val  <= data_in;
                last_mode <= mode_in;
                shreg     <= data_in;
                // Hex mode loads the raw value and skips the shift phase.
                accum     <= mode_in ? BCD_W'(data_in) : '0;
                iter      <= '0;
                busy      <= 1'b1;
            end else if (shift_en) begin
                {accum, shreg} <= {accum_adj, shreg} << 1;
                iter           <= iter + ITER_W'(1);
            end else if (finish) begin
                bcd_out <= accum;
                busy    <= 1'b0;
            end
        end
    end

    // Display refresh: blanking is derived from the published value so the
    // display never shows a half-converted accumulator.
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              wrap;
    logic [DIGITS-1:0] blank_v;
    logic              nz_above;
    logic [3:0]        nib_sel;
    logic [6:0]        seg_next;

    always_comb begin
        blank_v  = '0;
        nz_above = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            nz_above   = nz_above | (bcd_out[4*k +: 4] != 4'd0);
            blank_v[k] = ~nz_above;
        end
    end

    assign wrap     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_next = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    assign nib_sel  = bcd_out[idx_next*4 +: 4];

    result_seg7_display_decoder u_decoder (
        .nibble (nib_sel),
        .blank  (blank_v[idx_next]),
        .seg    (seg_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
            an  <= {{(DIGITS-1){1'b1}}, 1'b0};
            seg <= SEG_0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= idx_next;
            an  <= ~(DIGITS'(1) << idx_next);
            seg <= seg_next;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign dp = 1'b1;

endmodule
